psram_qspi_ctrl: RTL and testbench

Sequencing controller for the on-board 64 Mbit QSPI PSRAM, which is currently parked (CE_n high, SCK low, SIO high-Z). After reset it runs the device power-up/reset/QPI-enable sequence, then serves single 32-bit read/write word accesses over a valid/ready command port. It sits in the video clock domain between the top-level PSRAM pins (tristate resolved at top) and future frame-buffer/host requesters.

---
 rtl/psram_qspi_ctrl_pkg.sv | 48 ++++
 rtl/psram_qspi_ctrl_if.sv | 25 ++
 rtl/psram_qspi_ctrl_nibble_shifter.sv | 49 ++++
 rtl/psram_qspi_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_psram_qspi_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_qspi_ctrl_pkg.sv
// Shared opcodes, phase lengths, FSM state encoding and helpers for the QSPI PSRAM controller.
// Used by the controller top, the nibble shifter and the host-side interface.
package psram_qspi_ctrl_pkg;

  localparam int CMD_ADDR_W = 23;
  localparam int SCK_CNT_W  = 4;

  localparam logic [7:0] OP_RSTEN  = 8'h66;
  localparam logic [7:0] OP_RST    = 8'h99;
  localparam logic [7:0] OP_QPIEN  = 8'h35;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;

  localparam logic [SCK_CNT_W-1:0] SPI_OP_SCK = 4'd8;
  localparam logic [SCK_CNT_W-1:0] QCMD_SCK   = 4'd2;
  localparam logic [SCK_CNT_W-1:0] ADDR_SCK   = 4'd6;
  localparam logic [SCK_CNT_W-1:0] DATA_SCK   = 4'd8;

  localparam logic [3:0] ST_INIT_WAIT = 4'd0;
  localparam logic [3:0] ST_SPI       = 4'd1;
  localparam logic [3:0] ST_GAP       = 4'd2;
  localparam logic [3:0] ST_IDLE      = 4'd3;
  localparam logic [3:0] ST_CMD       = 4'd4;
  localparam logic [3:0] ST_ADDR      = 4'd5;
  localparam logic [3:0] ST_WAIT      = 4'd6;
  localparam logic [3:0] ST_DATA      = 4'd7;
  localparam logic [3:0] ST_END       = 4'd8;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } cmd_t;

  // Wire order on SIO is addr+0 first, so the word goes out byte-reversed.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] init_opcode(input logic [1:0] step);
    case (step)
      2'd0:    return OP_RSTEN;
      2'd1:    return OP_RST;
      default: return OP_QPIEN;
    endcase
  endfunction

endpackage

// File: rtl/psram_qspi_ctrl_if.sv
// Host-side command/read-data port of the PSRAM controller; requester uses master, controller slave.
// cmd_valid/cmd_ready handshake, single outstanding access, rdata_valid is a one-clock pulse.
interface psram_qspi_ctrl_if;
  import psram_qspi_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [CMD_ADDR_W-1:0] cmd_address;
  logic [31:0]           cmd_wdata;
  logic                  rdata_valid;
  logic [31:0]           rdata;
  logic                  init_done;

  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  cmd_ready, rdata_valid, rdata, init_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output cmd_ready, rdata_valid, rdata, init_done
  );

endinterface

// File: rtl/psram_qspi_ctrl_nibble_shifter.sv
// Loadable 32-bit shift register, MSB first, 1-bit (SPI) or 4-bit (QPI) per shift, with SCK down-counter.
// Zero latency: sio_out reflects the register; load wins over shift/tick; no backpressure.
module psram_nibble_shifter
  import psram_qspi_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [31:0]          load_dat,
  input  logic [SCK_CNT_W-1:0] load_cnt,
  input  logic                 shift,
  input  logic                 tick,
  input  logic                 quad,
  input  logic [3:0]           sio_in,
  output logic [3:0]           sio_out,
  output logic [31:0]          dat,
  output logic                 last
);

  logic [31:0]          sr_q, sr_d;
  logic [SCK_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_dat;
      cnt_d = load_cnt;
    end else begin
      if (shift) sr_d = quad ? {sr_q[27:0], sio_in} : {sr_q[30:0], 1'b0};
      if (tick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sio_out = quad ? sr_q[31:28] : {3'b000, sr_q[31]};
  assign dat     = sr_q;
  assign last    = (cnt_q == 4'd1);

endmodule

// File: rtl/psram_qspi_ctrl.sv
// QSPI PSRAM sequencer: power-up reset/QPI-enable, then single-word QPI reads/writes (SCK = clock/2).
// Write holds CE_n low 32 clocks, read 44; cmd_ready low from handshake until the access has ended.
module psram_qspi_ctrl
  import psram_qspi_ctrl_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES = 3780,
  parameter int unsigned READ_WAIT_SCK    = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  psram_qspi_ctrl_if.slave   host,
  output logic               psram_ce_n,
  output logic               psram_sck,
  output logic [3:0]         psram_sio_out,
  output logic [3:0]         psram_sio_oe,
  input  logic [3:0]         psram_sio_in
);

  localparam logic [15:0]          INIT_LAST = 16'(INIT_WAIT_CYCLES - 1);
  localparam logic [SCK_CNT_W-1:0] WAIT_SCK  = SCK_CNT_W'(READ_WAIT_SCK);

  logic [3:0]  state_q, state_d;
  logic        ph_q, ph_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        init_done_q, init_done_d;
  cmd_t        cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic                 sh_load, sh_shift, sh_tick, sh_last;
  logic [31:0]          sh_ld_dat, sh_dat;
  logic [SCK_CNT_W-1:0] sh_cnt;
  logic [3:0]           sh_out;
  logic                 cmd_ready, rd_data;

  assign cmd_ready = (state_q == ST_IDLE) && init_done_q;
  assign rd_data   = (state_q == ST_DATA) && !cmd_q.write;

  always_comb begin
    state_d       = state_q;
    ph_d          = 1'b0;
    step_d        = step_q;
    wait_cnt_d    = wait_cnt_q;
    init_done_d   = init_done_q;
    cmd_d         = cmd_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    sh_load       = 1'b0;
    sh_ld_dat     = '0;
    sh_cnt        = '0;
    sh_shift      = 1'b0;
    sh_tick       = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        if (wait_cnt_q == INIT_LAST) begin
          state_d   = ST_SPI;
          step_d    = 2'd0;
          sh_load   = 1'b1;
          sh_ld_dat = {init_opcode(2'd0), 24'h0};
          sh_cnt    = SPI_OP_SCK;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (wait_cnt_q == 16'd1) begin
          if (step_q == 2'd2) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d   = ST_SPI;
            step_d    = step_q + 2'd1;
            sh_load   = 1'b1;
            sh_ld_dat = {init_opcode(step_q + 2'd1), 24'h0};
            sh_cnt    = SPI_OP_SCK;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (host.cmd_valid && cmd_ready) begin
          cmd_d.write = host.cmd_write;
          cmd_d.addr  = host.cmd_address & ~23'd3;
          cmd_d.wdata = host.cmd_wdata;
          state_d     = ST_CMD;
          sh_load     = 1'b1;
          sh_ld_dat   = {(host.cmd_write ? OP_QWRITE : OP_QREAD), 24'h0};
          sh_cnt      = QCMD_SCK;
        end
      end
      ST_END: begin
        if (wait_cnt_q == 16'd1) state_d = ST_IDLE;
        else                     wait_cnt_d = wait_cnt_q + 16'd1;
      end
      ST_SPI, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA: begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          // Read nibbles are captured on the edge that raises SCK.
          sh_shift = rd_data;
        end else if (!sh_last) begin
          sh_tick  = 1'b1;
          sh_shift = (state_q != ST_WAIT) && !rd_data;
        end else begin
          case (state_q)
            ST_SPI: begin
              state_d    = ST_GAP;
              wait_cnt_d = '0;
            end
            ST_CMD: begin
              state_d   = ST_ADDR;
              sh_load   = 1'b1;
              sh_ld_dat = {1'b0, cmd_q.addr, 8'h00};
              sh_cnt    = ADDR_SCK;
            end
            ST_ADDR: begin
              sh_load = 1'b1;
              if (cmd_q.write) begin
                state_d   = ST_DATA;
                sh_ld_dat = byte_swap32(cmd_q.wdata);
                sh_cnt    = DATA_SCK;
              end else begin
                state_d = ST_WAIT;
                sh_cnt  = WAIT_SCK;
              end
            end
            ST_WAIT: begin
              state_d = ST_DATA;
              sh_load = 1'b1;
              sh_cnt  = DATA_SCK;
            end
            default: begin
              state_d    = ST_END;
              wait_cnt_d = '0;
              if (!cmd_q.write) begin
                rdata_d       = byte_swap32(sh_dat);
                rdata_valid_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT_WAIT;
      ph_q          <= 1'b0;
      step_q        <= 2'd0;
      wait_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      cmd_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      step_q        <= step_d;
      wait_cnt_q    <= wait_cnt_d;
      init_done_q   <= init_done_d;
      cmd_q         <= cmd_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  psram_nibble_shifter u_shifter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (sh_load),
    .load_dat (sh_ld_dat),
    .load_cnt (sh_cnt),
    .shift    (sh_shift),
    .tick     (sh_tick),
    .quad     (state_q != ST_SPI),
    .sio_in   (psram_sio_in),
    .sio_out  (sh_out),
    .dat      (sh_dat),
    .last     (sh_last)
  );

  always_comb begin
    psram_sio_oe = 4'b0000;
    if (state_q == ST_SPI) psram_sio_oe = 4'b0001;
    else if ((state_q == ST_CMD) || (state_q == ST_ADDR) ||
             ((state_q == ST_DATA) && cmd_q.write)) psram_sio_oe = 4'b1111;
  end

  assign psram_ce_n    = !(state_q inside {ST_SPI, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA});
  assign psram_sck     = ph_q;
  assign psram_sio_out = sh_out & psram_sio_oe;

  assign host.cmd_ready   = cmd_ready;
  assign host.init_done   = init_done_q;
  assign host.rdata_valid = rdata_valid_q;
  assign host.rdata       = rdata_q;

endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Scoreboarded bench: a pin-level PSRAM monitor/model checks each CE_n window and read word against queued expectations.
module tb_psram_qspi_ctrl;

  localparam int INIT_CYC = 10;
  localparam int INIT_DONE_CYC = INIT_CYC + 54;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       psram_ce_n, psram_sck;
  logic [3:0] psram_sio_out, psram_sio_oe;
  logic [3:0] psram_sio_in = 4'h0;

  psram_qspi_ctrl_if bus();

  psram_qspi_ctrl #(.INIT_WAIT_CYCLES(INIT_CYC), .READ_WAIT_SCK(6)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .host          (bus.slave),
    .psram_ce_n    (psram_ce_n),
    .psram_sck     (psram_sck),
    .psram_sio_out (psram_sio_out),
    .psram_sio_oe  (psram_sio_oe),
    .psram_sio_in  (psram_sio_in)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          n;
    logic [87:0] dat;
    logic [87:0] oe;
    int          fall;
    int          rise;
  } win_t;

  typedef struct {
    logic [31:0] d;
    int          at;
  } rd_t;

  win_t win_q[$];
  rd_t  rd_q[$];

  // ---------------- pin monitor, PSRAM read model and scoreboard ----------------
  logic [7:0]  mem [16];
  logic        mon_ce_prev = 1'b1;
  logic        mon_sck_prev = 1'b0;
  bit          init_seen = 1'b0;
  int          m_n, m_fall, j, idx;
  logic [87:0] m_dat, m_oe;
  logic [7:0]  m_op, b;
  logic [23:0] m_addr;
  win_t        e;
  rd_t         r;

  always @(negedge clock) begin
    if (!reset_n) begin
      mon_ce_prev  = 1'b1;
      mon_sck_prev = 1'b0;
      init_seen    = 1'b0;
      psram_sio_in = 4'h0;
    end else begin
      if (mon_ce_prev && !psram_ce_n) begin
        m_n = 0; m_dat = '0; m_oe = '0; m_op = '0; m_addr = '0; m_fall = cyc;
      end
      if (!psram_ce_n && psram_sck && !mon_sck_prev) begin
        m_n++;
        m_dat = {m_dat[83:0], psram_sio_out};
        m_oe  = {m_oe[83:0], psram_sio_oe};
        if (m_n == 2) m_op = m_dat[7:0];
        if (m_n == 8) m_addr = m_dat[23:0];
      end
      if (!psram_ce_n && !psram_sck && m_op == 8'hEB && m_n >= 14 && m_n < 22) begin
        j   = m_n - 14;
        idx = (int'(m_addr[3:0]) + j / 2) % 16;
        b   = mem[idx];
        psram_sio_in = (j % 2 == 0) ? b[7:4] : b[3:0];
      end else begin
        psram_sio_in = 4'hA;
      end
      if (!mon_ce_prev && psram_ce_n) begin
        if (win_q.size() == 0) begin
          check("unexpected_ce_window", 96'(m_fall), 96'hFFFF_FFFF);
        end else begin
          e = win_q.pop_front();
          check("win_sck_count", 96'(m_n), 96'(e.n));
          check("win_sio_out", {8'h0, m_dat}, {8'h0, e.dat});
          check("win_sio_oe", {8'h0, m_oe}, {8'h0, e.oe});
          check("win_ce_fall_cycle", 96'(m_fall), 96'(e.fall));
          check("win_ce_rise_cycle", 96'(cyc), 96'(e.rise));
        end
      end
      if (bus.rdata_valid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rdata_valid", 96'(bus.rdata), 96'hFFFF_FFFF_F);
        end else begin
          r = rd_q.pop_front();
          check("rdata", 96'(bus.rdata), 96'(r.d));
          check("rdata_valid_cycle", 96'(cyc), 96'(r.at));
        end
      end
      if (bus.init_done && !init_seen) begin
        init_seen = 1'b1;
        check("init_done_cycle", 96'(cyc), 96'(INIT_DONE_CYC));
      end else if (!bus.init_done && init_seen) begin
        check("init_done_dropped", 96'(bus.init_done), 96'd1);
      end
      mon_ce_prev  = psram_ce_n;
      mon_sck_prev = psram_sck;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_win(input int n, input logic [87:0] dat, input logic [87:0] oe,
                          input int fall, input int rise);
    win_t w;
    w.n = n; w.dat = dat; w.oe = oe; w.fall = fall; w.rise = rise;
    win_q.push_back(w);
  endtask

  task automatic push_init();
    push_win(8, 88'h01100110, 88'h11111111, 10, 26);
    push_win(8, 88'h10011001, 88'h11111111, 28, 44);
    push_win(8, 88'h00110101, 88'h11111111, 46, 62);
  endtask

  task automatic push_rd(input logic [31:0] d, input int at);
    rd_t x;
    x.d = d; x.at = at;
    rd_q.push_back(x);
  endtask

  // Holds cmd_valid high until accepted; t is the handshake cycle (-1 on timeout).
  task automatic issue(input logic wr, input logic [22:0] a, input logic [31:0] d, output int t);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_address = a;
    bus.cmd_wdata   = d;
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.cmd_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("cmd_accept_timeout", 96'd0, 96'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_state_check(input string name);
    check(name, 96'({psram_ce_n, psram_sck, psram_sio_out, psram_sio_oe,
                     bus.init_done, bus.cmd_ready, bus.rdata_valid}), 96'h1000);
  endtask

  localparam logic [87:0] OE_W = 88'hFFFFFFFFFFFFFFFF;
  localparam logic [87:0] OE_R = 88'hFFFFFFFF00000000000000;

  int t1, t2, t3, t4, t5, t6, t7;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6]  = 8'h33; mem[7]  = 8'h44;
    mem[8] = 8'h21; mem[9] = 8'h43; mem[10] = 8'h65; mem[11] = 8'h87;

    // cmd_valid is already high while the device is still being initialised.
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_address = 23'h000104;
    bus.cmd_wdata   = 32'hDDCCBBAA;
    repeat (3) @(negedge clock);
    reset_state_check("reset_outputs");
    check("reset_rdata", 96'(bus.rdata), 96'd0);
    push_init();
    reset_n = 1'b1;

    issue(1'b1, 23'h000104, 32'hDDCCBBAA, t1);
    check("first_accept_cycle", 96'(t1), 96'(INIT_DONE_CYC));
    push_win(16, 88'h38000104AABBCCDD, OE_W, t1 + 1, t1 + 33);

    issue(1'b0, 23'h000107, 32'h0, t2);
    check("ready_after_write", 96'(t2), 96'(t1 + 35));
    push_win(22, 88'hEB00010400000000000000, OE_R, t2 + 1, t2 + 45);
    push_rd(32'h44332211, t2 + 45);

    issue(1'b1, 23'h00010C, 32'h01234567, t3);
    check("ready_after_read", 96'(t3), 96'(t2 + 47));
    push_win(16, 88'h3800010C67452301, OE_W, t3 + 1, t3 + 33);

    issue(1'b0, 23'h00010A, 32'h0, t4);
    check("ready_after_write2", 96'(t4), 96'(t3 + 35));
    push_win(22, 88'hEB00010800000000000000, OE_R, t4 + 1, t4 + 45);
    push_rd(32'h87654321, t4 + 45);

    // Read aborted by reset in its DATA phase: no window or rdata expected.
    issue(1'b0, 23'h000104, 32'h0, t5);
    check("ready_after_read2", 96'(t5), 96'(t4 + 47));
    bus.cmd_write   = 1'b1;
    bus.cmd_address = 23'h000100;
    bus.cmd_wdata   = 32'hCAFEF00D;
    for (int i = 0; i < 100 && cyc != t5 + 35; i++) @(negedge clock);
    check("abort_point_reached", 96'(cyc), 96'(t5 + 35));
    check("abort_ce_low_in_data", 96'({psram_ce_n, psram_sio_oe}), 96'h00);
    #2;
    reset_n = 1'b0;
    #1;
    reset_state_check("async_reset_outputs");
    check("async_reset_rdata", 96'(bus.rdata), 96'd0);
    repeat (3) @(negedge clock);
    push_init();
    reset_n = 1'b1;

    issue(1'b1, 23'h000100, 32'hCAFEF00D, t6);
    check("accept_after_reinit", 96'(t6), 96'(INIT_DONE_CYC));
    push_win(16, 88'h380001000DF0FECA, OE_W, t6 + 1, t6 + 33);

    issue(1'b0, 23'h000106, 32'h0, t7);
    check("ready_after_write3", 96'(t7), 96'(t6 + 35));
    push_win(22, 88'hEB00010400000000000000, OE_R, t7 + 1, t7 + 45);
    push_rd(32'h44332211, t7 + 45);
    bus.cmd_valid = 1'b0;

    for (int i = 0; i < 300 && (win_q.size() != 0 || rd_q.size() != 0); i++) @(negedge clock);
    repeat (10) @(negedge clock);
    check("windows_outstanding", 96'(win_q.size()), 96'd0);
    check("reads_outstanding", 96'(rd_q.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
